// File: rtl/pe_edge_feeder.sv
// Edge feeder for one systolic-array lane: buffers an operand stream and issues
// one element at a time to the edge PE, with start skew and a last-element pulse.
module pe_edge_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  vec_len_i,
    input  logic [LEN_WIDTH-1:0]  skew_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] pe_data_o,
    output logic                  pe_valid_o,
    output logic                  pe_last_o,
    input  logic                  pe_ack_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKEW,
        ST_FETCH,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;

    logic [LEN_WIDTH-1:0]  vec_len_q;
    logic [LEN_WIDTH-1:0]  skew_cnt;
    logic [LEN_WIDTH-1:0]  elem_cnt;
    logic                  start_accept;
    logic                  elem_last;

    // FIFO runs in every state so the lane can prefetch while idle.
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign s_ready_o  = !fifo_full;
    assign push       = s_valid_i && !fifo_full;
    assign pop        = (state == ST_FETCH) && !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign start_accept = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign elem_last    = ((elem_cnt + LEN_WIDTH'(1)) == vec_len_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_accept) begin
                    if (vec_len_i == '0) begin
                        state_next = ST_DONE;
                    end else if (skew_i == '0) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_SKEW;
                    end
                end
            end
            ST_SKEW: begin
                if (skew_cnt == LEN_WIDTH'(1)) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (pe_ack_i) begin
                    state_next = elem_last ? ST_DONE : ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vec_len_q  <= '0;
            skew_cnt   <= '0;
            elem_cnt   <= '0;
            pe_data_o  <= '0;
            pe_valid_o <= 1'b0;
            pe_last_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            // pe_valid_o is high only in the first WAIT_ACK cycle, so last follows it by one.
            pe_valid_o <= pop;
            pe_last_o  <= pe_valid_o && elem_last;
            busy_o     <= (state_next == ST_SKEW) || (state_next == ST_FETCH) ||
                          (state_next == ST_WAIT_ACK);
            if (pop) begin
                pe_data_o <= mem[rd_ptr];
            end

            if (start_accept) begin
                if (vec_len_i == '0) begin
                    done_o <= 1'b1;
                end else begin
                    vec_len_q <= vec_len_i;
                    skew_cnt  <= skew_i;
                    elem_cnt  <= '0;
                    done_o    <= 1'b0;
                end
            end

            if (state == ST_SKEW) begin
                skew_cnt <= skew_cnt - LEN_WIDTH'(1);
            end

            if ((state == ST_WAIT_ACK) && pe_ack_i) begin
                elem_cnt <= elem_cnt + LEN_WIDTH'(1);
                if (elem_last) begin
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule
